multicycle_cpu: RTL
===================

Name: multicycle_cpu

Overview:
Parametrised successor to the single-shot fetch/decode/execute computer. It is a clocked multicycle processor with an on-chip program memory, a register file, a program counter and an ALU. The sequencing is a real FSM instead of delay-driven blocks. Programs are loaded through a write port, started with a pulse, and run until HALT; the register file is observable through a debug read port.

Parameters:
DATA_W, 32, datapath and register width (>=16)
IMEM_AW, 3, program memory address width; depth 2^IMEM_AW words of 32 bits
REG_AW, 3, register file address width; 2^REG_AW registers (max 4)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
load_en  input  1  write load_data into program memory at load_addr
load_addr  input  IMEM_AW  program memory write address
load_data  input  32  instruction word
start  input  1  begin execution at PC=0
dbg_addr  input  REG_AW  register file debug read address
dbg_data  output  DATA_W  combinational read of reg[dbg_addr]
out  output  DATA_W  value of the last register writeback
pc  output  IMEM_AW  current program counter
busy  output  1  high in FETCH/DECODE/EXEC/WB
done  output  1  one-cycle pulse on entry to HALTED

Behaviour:
- Instruction fields: op=[15:12], rd=[8+REG_AW-1:8], rs1=[4+REG_AW-1:4], rs2=[REG_AW-1:0], imm=[31:16].
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LDI (rd<=zero-extended imm), 6 BEQZ (if reg[rs1]==0 then PC<=imm[IMEM_AW-1:0]), 7 HALT, 8 MUL (see optional), others NOP.
- Arithmetic is modulo 2^DATA_W; no flags, no carry out.
- States: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH ..., and HALTED.
- Each instruction takes exactly 4 cycles. FETCH latches imem[pc] into IR. DECODE latches reg[rs1] and reg[rs2] into A/B. EXEC computes the ALU result into R. WB writes rd (ALU ops/LDI only), updates out and updates pc.
- PC update in WB: branch target if BEQZ is taken, else pc+1. Wraps from 2^IMEM_AW-1 to 0.
- HALT: WB does no write; pc holds at the HALT address; next state HALTED; done=1 for that first HALTED cycle only.
- start is sampled only in IDLE/HALTED: pc<=0, go to FETCH. It is ignored while busy.
- load_en is honoured only in IDLE/HALTED and is ignored while busy. If load_en and start occur in the same cycle, the write completes and FETCH of that address in the next cycle sees the new word.
- WB writes occur at the end of WB, so a following instruction's DECODE reads the new value. No hazards exist.
- Reset (any state, including mid-instruction): state=IDLE, pc=0, IR/A/B/R=0, out=0, busy=0, done=0, all registers=0. Program memory is not cleared.
- dbg_data reflects register contents after the clock edge; it never stalls execution.

Optional Feature:
MULTICYCLE_CPU_MUL_EN: when defined, op 8 gives rd <= low DATA_W bits of reg[rs1]*reg[rs2], still 4 cycles. When undefined, op 8 is a NOP: no write, out unchanged, pc+1.

Test Plan:
- Reset mid-EXEC of ADD -> next cycle busy=0, pc=0, out=0, dbg_data=0 for all registers; program memory intact, so rerunning start gives the correct result.
- Load LDI r1,5; LDI r2,7; ADD r3,r1,r2; HALT; then start -> out=12 after the 3rd WB, done pulses at cycle 16 after start, reg3=12, pc=3.
- SUB r3,r1,r2 with r1=5, r2=7 -> reg3=0xFFFFFFFE (DATA_W=32) wrap result.
- BEQZ r0 to addr 6 at addr 0, NOP at 6, NOP at 7, HALT at 0? Use: r0=0, branch taken -> pc sequence 0,6,7,0 (wrap), HALT at 0 after reload check; a not-taken branch with r1=5 gives pc+1.
- load_en and start pulsed while busy -> memory word unchanged and execution continues unaffected; load in HALTED then start -> new program runs.
- op 8 with r1=3, r2=4: with MULTICYCLE_CPU_MUL_EN defined reg3=12; without it reg3 unchanged and pc advances by 1.

Source files
------------

// File: rtl/multicycle_cpu.sv
// Multicycle processor: program memory, register file and ALU sequenced FETCH/DECODE/EXEC/WB.
// Define MULTICYCLE_CPU_MUL_EN to enable the op-8 multiply; otherwise op 8 executes as a NOP.
module multicycle_cpu #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMEM_AW = 3,
    parameter int unsigned REG_AW  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [IMEM_AW-1:0] load_addr,
    input  logic [31:0]        load_data,
    input  logic               start,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [DATA_W-1:0]  out,
    output logic [IMEM_AW-1:0] pc,
    output logic               busy,
    output logic               done
);

    localparam int unsigned ImemDepth = 1 << IMEM_AW;
    localparam int unsigned NumRegs   = 1 << REG_AW;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpLdi  = 4'd5;
    localparam logic [3:0] OpBeqz = 4'd6;
    localparam logic [3:0] OpHalt = 4'd7;
`ifdef MULTICYCLE_CPU_MUL_EN
    localparam logic [3:0] OpMul  = 4'd8;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalted
    } state_e;

    state_e             state_q;
    logic [IMEM_AW-1:0] pc_q;
    logic [31:0]        ir_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  r_q;
    logic [DATA_W-1:0]  out_q;
    logic               busy_q;
    logic               done_q;
    logic [DATA_W-1:0]  regs_q [NumRegs];
    logic [31:0]        imem_q [ImemDepth];

    logic [3:0]         op;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic               idle_like;
    logic [DATA_W-1:0]  alu_res;
    logic               wr_en;
    logic               br_taken;
    logic [IMEM_AW-1:0] pc_next;
    logic               ir_unused;

    assign op        = ir_q[15:12];
    assign rd        = ir_q[8 +: REG_AW];
    assign rs1       = ir_q[4 +: REG_AW];
    assign rs2       = ir_q[0 +: REG_AW];
    assign idle_like = (state_q == StIdle) || (state_q == StHalted);
    assign ir_unused = ^ir_q;

    always_comb begin
        alu_res = '0;
        wr_en   = 1'b0;
        case (op)
            OpAdd: begin
                alu_res = a_q + b_q;
                wr_en   = 1'b1;
            end
            OpSub: begin
                alu_res = a_q - b_q;
                wr_en   = 1'b1;
            end
            OpAnd: begin
                alu_res = a_q & b_q;
                wr_en   = 1'b1;
            end
            OpOr: begin
                alu_res = a_q | b_q;
                wr_en   = 1'b1;
            end
            OpXor: begin
                alu_res = a_q ^ b_q;
                wr_en   = 1'b1;
            end
            OpLdi: begin
                alu_res = DATA_W'(ir_q[31:16]);
                wr_en   = 1'b1;
            end
`ifdef MULTICYCLE_CPU_MUL_EN
            OpMul: begin
                alu_res = a_q * b_q;
                wr_en   = 1'b1;
            end
`endif
            default: begin
                alu_res = '0;
                wr_en   = 1'b0;
            end
        endcase
    end

    // A still holds reg[rs1] during WB, so the branch decision is made there.
    assign br_taken = (op == OpBeqz) && (a_q == '0);
    assign pc_next  = br_taken ? ir_q[16 +: IMEM_AW] : pc_q + 1'b1;

    // Program memory is deliberately left out of reset so a loaded program survives it.
    always_ff @(posedge clk) begin
        if (load_en && idle_like) begin
            imem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StHalted: begin
                    if (start) begin
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    ir_q    <= imem_q[pc_q];
                    state_q <= StDecode;
                end
                StDecode: begin
                    a_q     <= regs_q[rs1];
                    b_q     <= regs_q[rs2];
                    state_q <= StExec;
                end
                StExec: begin
                    r_q     <= alu_res;
                    state_q <= StWb;
                end
                StWb: begin
                    if (op == OpHalt) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StHalted;
                    end else begin
                        if (wr_en) begin
                            regs_q[rd] <= r_q;
                            out_q      <= r_q;
                        end
                        pc_q    <= pc_next;
                        state_q <= StFetch;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dbg_data = regs_q[dbg_addr];
    assign out      = out_q;
    assign pc       = pc_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
